// File: rtl/ped_xing_pkg.sv
// Shared definitions for the pedestrian crossing slice: light patterns,
// request-unit state type and debounce counter width.
package ped_xing_pkg;

    localparam logic [4:0] LS_TRAFFIC_GO = 5'b01001;
    localparam logic [4:0] LS_PED_WALK   = 5'b10100;
    localparam logic [4:0] LS_AMBER      = 5'b01110;

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PENDING  = 2'd2,
        SERVED   = 2'd3
    } ped_state_e;

    function automatic logic is_walk(input logic [4:0] ls);
        return ls == LS_PED_WALK;
    endfunction

endpackage

// File: rtl/btn_sync_debounce.sv
// Two-flop synchroniser for the raw push-button, with an optional stand-alone
// level debouncer (DEBOUNCE_CYCLES = 0 passes the synchronised level through).
module btn_sync_debounce
    import ped_xing_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic button_i,
    output logic btn_s_o
);

    logic sync1_q, sync2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= button_i;
            sync2_q <= sync1_q;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_raw
            assign btn_s_o = sync2_q;
        end else begin : g_db
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             level_q, level_d;

            // The output level flips only after the input has disagreed with it
            // for DEBOUNCE_CYCLES consecutive cycles.
            always_comb begin
                cnt_d   = '0;
                level_d = level_q;
                if (sync2_q != level_q) begin
                    if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        level_d = sync2_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                end else begin
                    cnt_q   <= cnt_d;
                    level_q <= level_d;
                end
            end

            assign btn_s_o = level_q;
        end
    endgenerate

endmodule

// File: rtl/ped_request_unit.sv
// Pedestrian request front end: debounces the button, holds start until walk,
// counts served requests. PED_WAIT_BLINK_EN makes the WAIT lamp blink in PENDING.
module ped_request_unit
    import ped_xing_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = 4,
    parameter int unsigned BLINK_HALF_PERIOD = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       button,
    input  logic [4:0] lightseq,
    output logic       start,
    output logic       wait_lamp,
    output logic [7:0] served_count
);

    generate
        if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
            $error("DEBOUNCE_CYCLES out of range 1..255");
        end
        if (BLINK_HALF_PERIOD < 1 || BLINK_HALF_PERIOD > 255) begin : g_bad_blink
            $error("BLINK_HALF_PERIOD out of range 1..255");
        end
    endgenerate

    ped_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q, start_d;
    logic             lamp_q, lamp_d;
    logic [7:0]       served_q, served_d;
    logic             btn_s;
    logic             walk;

    btn_sync_debounce #(
        .DEBOUNCE_CYCLES(0)
    ) u_sync (
        .clk_i   (clock),
        .rst_ni  (reset),
        .button_i(button),
        .btn_s_o (btn_s)
    );

    assign walk = is_walk(lightseq);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        served_d = served_q;
        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = DEBOUNCE;
                    cnt_d   = CNT_W'(1);
                end
            end
            DEBOUNCE: begin
                // Priority: bounce abort, then walk already showing, then threshold.
                if (!btn_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (walk) begin
                    state_d = SERVED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
                    state_d = PENDING;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PENDING: begin
                if (walk) begin
                    state_d = SERVED;
                    if (served_q != '1) begin
                        served_d = served_q + 8'd1;
                    end
                end
            end
            SERVED: begin
                if (!btn_s && !walk) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        start_d = (state_d == PENDING);
    end

`ifdef PED_WAIT_BLINK_EN
    logic [7:0] blink_q, blink_d;

    always_comb begin
        blink_d = '0;
        lamp_d  = 1'b0;
        if (state_d == PENDING) begin
            if (state_q != PENDING) begin
                lamp_d = 1'b1;
            end else if (blink_q == 8'(BLINK_HALF_PERIOD - 1)) begin
                lamp_d = ~lamp_q;
            end else begin
                lamp_d  = lamp_q;
                blink_d = blink_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            blink_q <= '0;
        end else begin
            blink_q <= blink_d;
        end
    end
`else
    always_comb begin
        lamp_d = (state_d == PENDING);
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            start_q  <= 1'b0;
            lamp_q   <= 1'b0;
            served_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            start_q  <= start_d;
            lamp_q   <= lamp_d;
            served_q <= served_d;
        end
    end

    assign start        = start_q;
    assign wait_lamp    = lamp_q;
    assign served_count = served_q;

endmodule
